// File: rtl/ram_march_bist.sv
// March BIST initiator for a single-port no-change RAM: runs a 4-element March
// sequence (w0; r0,w1 up; r1,w0 down; r0 up), reports pass and the first mismatch.
module ram_march_bist #(
  parameter int unsigned addressWidth = 5,
  parameter int unsigned dataWidth    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [addressWidth-1:0] ram_address,
  output logic [dataWidth-1:0]    ram_din,
  input  logic [dataWidth-1:0]    ram_dout,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [addressWidth-1:0] fail_address,
  output logic [dataWidth-1:0]    fail_expected,
  output logic [dataWidth-1:0]    fail_actual
);

  localparam logic [addressWidth-1:0] AddrMax = '1;
  localparam logic [addressWidth-1:0] AddrMin = '0;
  localparam logic [dataWidth-1:0]    P0      = '0;
  localparam logic [dataWidth-1:0]    P1      = '1;

  typedef enum logic [3:0] {
    StIdle, StM0W, StM1R, StM1W, StM2R, StM2W, StM3R, StDrain, StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [addressWidth-1:0] addr_q, addr_d;
  logic                    start_run;
  logic                    rd_op;
  logic [dataWidth-1:0]    rd_exp;

  logic                    cmp_valid_q;
  logic [addressWidth-1:0] cmp_addr_q;
  logic [dataWidth-1:0]    cmp_exp_q;
  logic                    mismatch;
  logic                    fail_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    start_run = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StM0W;
          addr_d    = AddrMin;
          start_run = 1'b1;
        end
      end
      StM0W: begin
        if (addr_q == AddrMax) begin
          state_d = StM1R;
          addr_d  = AddrMin;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StM1R: state_d = StM1W;
      StM1W: begin
        // M2 walks back down from the top, so the counter stays at N-1
        if (addr_q == AddrMax) begin
          state_d = StM2R;
        end else begin
          state_d = StM1R;
          addr_d  = addr_q + 1'b1;
        end
      end
      StM2R: state_d = StM2W;
      StM2W: begin
        if (addr_q == AddrMin) begin
          state_d = StM3R;
        end else begin
          state_d = StM2R;
          addr_d  = addr_q - 1'b1;
        end
      end
      StM3R: begin
        if (addr_q == AddrMax) begin
          state_d = StDrain;
          addr_d  = AddrMin;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // RAM pins come from registers only, never from start or ram_dout.
  always_comb begin
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_din     = P0;
    ram_address = '0;
    busy        = 1'b0;
    done        = 1'b0;
    rd_op       = 1'b0;
    rd_exp      = P0;
    unique case (state_q)
      StM0W, StM1W, StM2W: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
        busy   = 1'b1;
      end
      StM1R, StM2R, StM3R: begin
        ram_en = 1'b1;
        busy   = 1'b1;
        rd_op  = 1'b1;
      end
      StDrain: busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
    if (ram_en) ram_address = addr_q;
    if (state_q == StM1W) ram_din = P1;
    if (state_q == StM2R) rd_exp = P1;
  end

  assign pass = done & ~fail_q;

  // Read data arrives one cycle after the read, so the expectation is staged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_exp_q   <= '0;
    end else begin
      cmp_valid_q <= rd_op;
      if (rd_op) begin
        cmp_addr_q <= addr_q;
        cmp_exp_q  <= rd_exp;
      end
    end
  end

  assign mismatch = cmp_valid_q && (ram_dout != cmp_exp_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_q        <= 1'b0;
      fail_address  <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else if (start_run) begin
      fail_q        <= 1'b0;
      fail_address  <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else if (mismatch && !fail_q) begin
      fail_q        <= 1'b1;
      fail_address  <= cmp_addr_q;
      fail_expected <= cmp_exp_q;
      fail_actual   <= ram_dout;
    end
  end

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist with a no-change RAM model and injectable read faults.
module tb_ram_march_bist;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy, done, pass;
  logic [AW-1:0] fail_address;
  logic [DW-1:0] fail_expected, fail_actual;

  int checks = 0;
  int passes = 0;

  // 0: healthy, 1: bit3 stuck-at-0 at address 7, 2: bit0 stuck-at-1 everywhere
  int            fault_mode = 0;
  logic [DW-1:0] mem [N];
  logic [DW-1:0] raw_dout;
  logic [AW-1:0] rd_addr;

  always #5 clk = ~clk;

  ram_march_bist #(.addressWidth(AW), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_en(ram_en), .ram_we(ram_we), .ram_address(ram_address), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy), .done(done), .pass(pass),
    .fail_address(fail_address), .fail_expected(fail_expected), .fail_actual(fail_actual)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_address] <= ram_din;
      end else begin
        raw_dout <= mem[ram_address];
        rd_addr  <= ram_address;
      end
    end
  end

  always_comb begin
    ram_dout = raw_dout;
    if (fault_mode == 1 && rd_addr == 5'd7) ram_dout = raw_dout & ~32'h8;
    if (fault_mode == 2) ram_dout = raw_dout | 32'h1;
  end

  // Drives a start pulse (or holds it), then counts busy and ram_en cycles
  // until busy falls; addresses seen during the M2 window are checked in order.
  int busy_cycles, en_cycles, m2_bad;
  task automatic run_test(input bit hold);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    busy_cycles = 0;
    en_cycles   = 0;
    m2_bad      = 0;
    while (busy && busy_cycles < 1000) begin
      if (ram_en) en_cycles++;
      if (busy_cycles >= 3 * N && busy_cycles < 5 * N) begin
        if (ram_address !== AW'(N - 1 - (busy_cycles - 3 * N) / 2)) m2_bad++;
      end
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ram_en, ram_we, ram_address, ram_din, busy, done, pass} !== '0)
      $display("FAIL reset_pins: en=%b we=%b addr=%0d din=%h busy=%b done=%b pass=%b, want all 0",
               ram_en, ram_we, ram_address, ram_din, busy, done, pass);
    else passes++;
    checks++;
    if ({fail_address, fail_expected, fail_actual} !== '0)
      $display("FAIL reset_fail_regs: addr=%0d exp=%h act=%h, want 0",
               fail_address, fail_expected, fail_actual);
    else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ram_en, busy, done} !== 3'b000)
      $display("FAIL idle_after_reset: en=%b busy=%b done=%b, want 000", ram_en, busy, done);
    else passes++;
  endtask

  task automatic test_healthy();
    int nz;
    fault_mode = 0;
    run_test(1'b0);
    checks++;
    if (busy_cycles !== 193) $display("FAIL healthy_busy_len: got %0d, want 193", busy_cycles);
    else passes++;
    checks++;
    if (en_cycles !== 192) $display("FAIL healthy_en_cycles: got %0d, want 192", en_cycles);
    else passes++;
    checks++;
    if ({done, pass} !== 2'b11) $display("FAIL healthy_done_pass: got %b%b, want 11", done, pass);
    else passes++;
    checks++;
    if (m2_bad !== 0) $display("FAIL m2_address_order: %0d bad addresses, want 0", m2_bad);
    else passes++;
    nz = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== '0) nz++;
    checks++;
    if (nz !== 0) $display("FAIL final_contents: %0d nonzero words, want 0", nz);
    else passes++;
  endtask

  task automatic test_stuck0();
    fault_mode = 1;
    run_test(1'b0);
    checks++;
    if ({done, pass} !== 2'b10) $display("FAIL sa0_done_pass: got %b%b, want 10", done, pass);
    else passes++;
    checks++;
    if (fail_address !== 5'd7 || fail_expected !== 32'hFFFF_FFFF || fail_actual !== 32'hFFFF_FFF7)
      $display("FAIL sa0_capture: addr=%0d exp=%h act=%h, want 7 ffffffff fffffff7",
               fail_address, fail_expected, fail_actual);
    else passes++;
  endtask

  task automatic test_stuck1();
    fault_mode = 2;
    run_test(1'b0);
    checks++;
    if ({done, pass} !== 2'b10) $display("FAIL sa1_done_pass: got %b%b, want 10", done, pass);
    else passes++;
    checks++;
    if (fail_address !== 5'd0 || fail_expected !== 32'h0 || fail_actual !== 32'h1)
      $display("FAIL sa1_capture: addr=%0d exp=%h act=%h, want 0 00000000 00000001",
               fail_address, fail_expected, fail_actual);
    else passes++;
    checks++;
    if (busy_cycles !== 193) $display("FAIL sa1_no_abort: busy %0d cycles, want 193", busy_cycles);
    else passes++;
  endtask

  task automatic test_reset_mid_run();
    fault_mode = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    checks++;
    if (fail_actual !== 32'h1) $display("FAIL midrun_pre_capture: act=%h, want 00000001", fail_actual);
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if ({ram_en, busy, done} !== 3'b000)
      $display("FAIL midrun_reset_pins: en=%b busy=%b done=%b, want 000", ram_en, busy, done);
    else passes++;
    checks++;
    if ({fail_address, fail_expected, fail_actual} !== '0)
      $display("FAIL midrun_reset_fail: addr=%0d exp=%h act=%h, want 0",
               fail_address, fail_expected, fail_actual);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    fault_mode = 0;
    @(negedge clk);
    run_test(1'b0);
    checks++;
    if ({busy_cycles, done, pass} !== {32'd193, 2'b11})
      $display("FAIL midrun_rerun: busy=%0d done=%b pass=%b, want 193 1 1", busy_cycles, done, pass);
    else passes++;
  endtask

  task automatic test_start_held();
    int guard;
    fault_mode = 0;
    run_test(1'b1);
    checks++;
    if (busy_cycles !== 193) $display("FAIL held_no_restart: busy %0d cycles, want 193", busy_cycles);
    else passes++;
    checks++;
    if ({done, pass} !== 2'b11) $display("FAIL held_done: got %b%b, want 11", done, pass);
    else passes++;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done, pass, ram_en, ram_we, ram_address} !== {5'b10011, 5'd0})
      $display("FAIL held_reenter: busy=%b done=%b pass=%b en=%b we=%b addr=%0d, want 1 0 0 1 1 0",
               busy, done, pass, ram_en, ram_we, ram_address);
    else passes++;
    guard = 0;
    while (!done && guard < 1000) begin
      guard++;
      @(negedge clk);
    end
    checks++;
    if ({done, pass} !== 2'b11) $display("FAIL held_second_run: got %b%b, want 11", done, pass);
    else passes++;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    test_reset();
    test_healthy();
    test_stuck0();
    test_stuck1();
    test_reset_mid_run();
    test_start_held();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
